vpu_mem_arb: RTL and testbench
==============================

# vpu_mem_arb

Round-robin arbiter that shares one single-ported scratchpad memory between N_REQ requesters: the VPU operand/result port, the host loader and the systolic-array spill path. Each requester issues one-word reads or writes over a valid/ready handshake. A requester can lock the port across a multi-access sequence, such as the VPU's A / B / constant fetch followed by its C write-back. Read data is returned to the issuing requester after a fixed memory latency.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 16, memory address width
- N_REQ, 2, number of requesters (2..8); index 0 is the VPU
- RD_LAT, 1, memory read latency in cycles (1..4)

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester access request
- req_we  in  N_REQ  1 = write, 0 = read
- req_lock  in  N_REQ  hold the grant after this access
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  flattened write data
- req_ready  out  N_REQ  access accepted this cycle (one-hot or zero)
- rsp_valid  out  N_REQ  read data valid for requester i (one-hot or zero)
- rsp_data  out  DATA_W  read data, shared by all requesters
- mem_rdy  in  1  memory can accept an access this cycle
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read strobe

## Operation
**State**
- FSM state: ARB or LOCKED.
- Round-robin pointer ptr, width clog2(N_REQ).
- owner register.
- Response pipeline: RD_LAT stages, each holding {valid, id}.

**Arbitration (combinational)**
- ARB: winner = first i with req_valid[i], scanning ptr, ptr+1, … modulo N_REQ.
- LOCKED: winner = owner only, and only if req_valid[owner] is high.
- req_ready[winner] = mem_rdy; all other req_ready bits are 0.

**Transfer**
- A transfer occurs when req_valid[i] && req_ready[i].
- On a transfer: mem_en = 1, and mem_we / mem_addr / mem_wdata are the winner's slices.
- With no transfer: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.

**FSM transitions**
- ARB, transfer by i with req_lock[i] = 1 → LOCKED, owner = i; ptr unchanged.
- ARB, transfer by i with req_lock[i] = 0 → stay ARB, ptr = (i+1) mod N_REQ.
- LOCKED, owner transfers with req_lock = 0 → ARB, ptr = (owner+1) mod N_REQ. This is the last locked access.
- LOCKED, owner transfers with req_lock = 1 → stay LOCKED.
- LOCKED, owner deasserts req_valid → stay LOCKED; no other requester is granted. No timeout.

**Responses**
- A read transfer pushes {1, i} into pipeline stage 0. A write pushes {0, x}.
- The pipeline shifts every cycle. It never stalls, and mem_rdy does not affect it.
- At the last stage: if valid, rsp_valid[id] = 1 and rsp_data = mem_rdata. Otherwise rsp_valid = 0 and rsp_data = 0.
- Writes produce no response.

**Width rules**
- Addresses and data pass through unmodified; there is no address translation.
- A req_lock value on a non-transferring cycle is ignored.

## Timing
- Reset (rst = 0, asynchronous): state = ARB, ptr = 0, owner = 0, response pipeline cleared.
- While rst = 0, every output is forced to 0: req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata.
- Reset in the middle of a lock or with reads in flight: the lock is released and in-flight responses are discarded (no rsp_valid after release).
- Grant latency: 0 cycles. req_ready is combinational in the request cycle, given mem_rdy and an available grant.
- Read latency: rsp_valid rises exactly RD_LAT cycles after the accepting edge and lasts 1 cycle.
- Back-to-back transfers: one per cycle while mem_rdy = 1. This holds across requesters and within a lock.
- mem_rdy = 0: no req_ready and no transfer. State and ptr hold; responses already in the pipeline still drain.
- Simultaneous requests: exactly one grant per cycle, never more.
- Fairness: in ARB with all requesters asserting continuously and no locks, each gets one grant every N_REQ cycles.
- Requesters must hold req_* stable while req_valid = 1 && req_ready = 0. This is checked by assertion, not by logic.

## Test plan
- **Reset defaults:** N_REQ = 2, RD_LAT = 1, hold rst = 0 with both req_valid = 1 → all outputs 0. Release rst → requester 0 gets req_ready first (ptr = 0).
- **Round robin:** both requesters read continuously with req_lock = 0 and mem_rdy = 1 → grants alternate 0, 1, 0, 1. Each rsp_valid pulse arrives 1 cycle after its grant and carries mem_rdata.
- **Lock:** requester 0 issues reads at addresses 0x0004 and 0x0005 with lock = 1, then a write to 0x0006 of 0xDEADBEEF with lock = 0, while requester 1 requests throughout → requester 1 is not granted until the cycle after the write. ptr then = 1.
- **Lock gap:** owner drops req_valid for 3 cycles mid-lock → no req_ready to anyone for those cycles; the owner resumes and completes.
- **Backpressure:** mem_rdy = 0 for 2 cycles while a read issued in the previous cycle is in flight → no new grants. The pending rsp_valid still fires on time, and ptr is unchanged.
- **Reset mid-flight:** RD_LAT = 3, issue a read, then pulse rst = 0 for 1 cycle at +1 → no rsp_valid ever appears for that read, and state returns to ARB.

Source files
------------

// File: rtl/vpu_mem_arb_if.sv
// Requester-side and memory-side signal bundle for the scratchpad arbiter.
// The arbiter takes the slave modport; requesters/memory models take master.
interface vpu_mem_arb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned N_REQ  = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    mem_rdy;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdy, mem_rdata,
        output req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdy, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vpu_mem_arb.sv
// Round-robin arbiter with per-requester locking for a single-ported scratchpad.
// Read responses return on a fixed RD_LAT-deep tag pipeline that never stalls.
module vpu_mem_arb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned RD_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    vpu_mem_arb_if.slave bus
);
    localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [IdW-1:0] id_t;
    typedef enum logic [0:0] {StArb, StLocked} state_e;

    state_e            state_q, state_d;
    id_t               ptr_q, ptr_d;
    id_t               owner_q, owner_d;
    logic [RD_LAT-1:0] pipe_vld_q;
    id_t               pipe_id_q [RD_LAT];

    logic              grant_vld;
    id_t               winner;
    id_t               cand;
    logic [IdW:0]      sum;
    logic              xfer;

    function automatic id_t wrap_inc(input id_t v);
        return (32'(v) == N_REQ - 1) ? '0 : id_t'(v + 1'b1);
    endfunction

    // Winner selection: owner only while locked, else rotating priority from ptr.
    always_comb begin
        grant_vld = 1'b0;
        winner    = ptr_q;
        cand      = ptr_q;
        sum       = '0;
        if (state_q == StLocked) begin
            winner    = owner_q;
            grant_vld = bus.req_valid[owner_q];
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                sum = {1'b0, ptr_q} + (IdW + 1)'(k);
                if (sum >= (IdW + 1)'(N_REQ)) begin
                    sum = sum - (IdW + 1)'(N_REQ);
                end
                cand = sum[IdW-1:0];
                if (!grant_vld && bus.req_valid[cand]) begin
                    grant_vld = 1'b1;
                    winner    = cand;
                end
            end
        end
    end

    assign xfer = rst && grant_vld && bus.mem_rdy;

    always_comb begin
        bus.req_ready = '0;
        if (xfer) begin
            bus.req_ready[winner] = 1'b1;
        end
        bus.mem_en    = xfer;
        bus.mem_we    = xfer && bus.req_we[winner];
        bus.mem_addr  = xfer ? bus.req_addr[32'(winner)*ADDR_W +: ADDR_W] : '0;
        bus.mem_wdata = xfer ? bus.req_wdata[32'(winner)*DATA_W +: DATA_W] : '0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (xfer) begin
            unique case (state_q)
                StArb: begin
                    if (bus.req_lock[winner]) begin
                        state_d = StLocked;
                        owner_d = winner;
                    end else begin
                        ptr_d = wrap_inc(winner);
                    end
                end
                StLocked: begin
                    // Unlocked access by the owner is the last one of the sequence.
                    if (!bus.req_lock[owner_q]) begin
                        state_d = StArb;
                        ptr_d   = wrap_inc(owner_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StArb;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_id_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= xfer && !bus.req_we[winner];
            pipe_id_q[0]  <= winner;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if (rst && pipe_vld_q[RD_LAT-1]) begin
            bus.rsp_valid[pipe_id_q[RD_LAT-1]] = 1'b1;
            bus.rsp_data                       = bus.mem_rdata;
        end
    end

    // A stalled requester must keep its request unchanged until accepted.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stable
        assert property (@(posedge clk) disable iff (!rst)
            (bus.req_valid[gi] && !bus.req_ready[gi]) |=>
            (!bus.req_valid[gi] ||
             ($stable(bus.req_we[gi]) && $stable(bus.req_lock[gi]) &&
              $stable(bus.req_addr[gi*ADDR_W +: ADDR_W]) &&
              $stable(bus.req_wdata[gi*DATA_W +: DATA_W]))));
    end
endmodule

// File: tb/tb_vpu_mem_arb.sv
// Directed bench for vpu_mem_arb: RD_LAT=1 instance for arbitration/locking/backpressure,
// RD_LAT=3 instance for reset with a read in flight. Responses checked via scoreboard.
module tb_vpu_mem_arb;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        int          id;
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic [31:0] wr_mem [logic [15:0]];

    vpu_mem_arb_if #(.DATA_W(32), .ADDR_W(16), .N_REQ(2)) bus_a ();
    vpu_mem_arb_if #(.DATA_W(32), .ADDR_W(16), .N_REQ(2)) bus_b ();

    vpu_mem_arb #(.DATA_W(32), .ADDR_W(16), .N_REQ(2), .RD_LAT(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    vpu_mem_arb #(.DATA_W(32), .ADDR_W(16), .N_REQ(2), .RD_LAT(3)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scratchpad model for instance A: unwritten words read as {C0DE, addr}.
    always @(posedge clk) begin
        if (bus_a.mem_en) begin
            if (bus_a.mem_we) begin
                wr_mem[bus_a.mem_addr] = bus_a.mem_wdata;
            end else if (wr_mem.exists(bus_a.mem_addr)) begin
                bus_a.mem_rdata <= wr_mem[bus_a.mem_addr];
            end else begin
                bus_a.mem_rdata <= {16'hC0DE, bus_a.mem_addr};
            end
        end
    end

    assign bus_b.mem_rdata = 32'h0BAD_F00D;

    // Drives one cycle on instance A; called at posedge+1, returns at next posedge+1.
    task automatic vec(input string name, input logic [1:0] v, input logic [1:0] we,
                       input logic [1:0] lk, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [31:0] d0, input logic rdy, input logic [1:0] exp_rdy,
                       input logic [31:0] exp_rd);
        logic        g;
        logic [49:0] exp_mem;
        logic [49:0] act_mem;
        bus_a.req_valid = v;
        bus_a.req_we    = we;
        bus_a.req_lock  = lk;
        bus_a.req_addr  = {a1, a0};
        bus_a.req_wdata = {32'h0, d0};
        bus_a.mem_rdy   = rdy;
        #2;
        checks++;
        if (bus_a.req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s ready: got %b want %b", name, bus_a.req_ready, exp_rdy);
        end
        g       = exp_rdy[1];
        exp_mem = '0;
        if (exp_rdy != 2'b00) begin
            exp_mem = {1'b1, we[g], (g ? a1 : a0), (g ? 32'h0 : d0)};
            if (!we[g]) begin
                qa.push_back('{id: int'(g), due: cyc + 1, data: exp_rd});
            end
        end
        act_mem = {bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata};
        checks++;
        if (act_mem !== exp_mem) begin
            failures++;
            $display("FAIL %s mem: got en/we/addr/wdata=%h want %h", name, act_mem, exp_mem);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic vec_b(input string name, input logic [1:0] v, input logic [1:0] lk,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [1:0] exp_rdy, input logic push);
        bus_b.req_valid = v;
        bus_b.req_we    = 2'b00;
        bus_b.req_lock  = lk;
        bus_b.req_addr  = {a1, a0};
        bus_b.req_wdata = '0;
        #2;
        checks++;
        if (bus_b.req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s ready: got %b want %b", name, bus_b.req_ready, exp_rdy);
        end
        if (push) begin
            qb.push_back('{id: int'(exp_rdy[1]), due: cyc + 3, data: 32'h0BAD_F00D});
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitors: every pulse must match the head of its queue on the due cycle.
    always @(negedge clk) begin
        if (bus_a.rsp_valid != 2'b00 || (qa.size() > 0 && qa[0].due == cyc)) begin
            checks++;
            if (qa.size() == 0) begin
                failures++;
                $display("FAIL rsp_a unexpected: got valid=%b data=%h want none",
                         bus_a.rsp_valid, bus_a.rsp_data);
            end else begin
                if (bus_a.rsp_valid !== 2'(1 << qa[0].id) || bus_a.rsp_data !== qa[0].data ||
                    qa[0].due != cyc) begin
                    failures++;
                    $display("FAIL rsp_a: got valid=%b data=%h cyc=%0d want valid=%b data=%h cyc=%0d",
                             bus_a.rsp_valid, bus_a.rsp_data, cyc, 2'(1 << qa[0].id),
                             qa[0].data, qa[0].due);
                end
                void'(qa.pop_front());
            end
        end else begin
            checks++;
            if (bus_a.rsp_data !== 32'h0) begin
                failures++;
                $display("FAIL rsp_a idle data: got %h want 0", bus_a.rsp_data);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.rsp_valid != 2'b00 || (qb.size() > 0 && qb[0].due == cyc)) begin
            checks++;
            if (qb.size() == 0) begin
                failures++;
                $display("FAIL rsp_b unexpected: got valid=%b data=%h want none",
                         bus_b.rsp_valid, bus_b.rsp_data);
            end else begin
                if (bus_b.rsp_valid !== 2'(1 << qb[0].id) || bus_b.rsp_data !== qb[0].data ||
                    qb[0].due != cyc) begin
                    failures++;
                    $display("FAIL rsp_b: got valid=%b data=%h cyc=%0d want valid=%b data=%h cyc=%0d",
                             bus_b.rsp_valid, bus_b.rsp_data, cyc, 2'(1 << qb[0].id),
                             qb[0].data, qb[0].due);
                end
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.req_valid = '0;
        bus_a.req_we    = '0;
        bus_a.req_lock  = '0;
        bus_a.req_addr  = '0;
        bus_a.req_wdata = '0;
        bus_a.mem_rdy   = 1'b0;
        bus_b.req_valid = '0;
        bus_b.req_we    = '0;
        bus_b.req_lock  = '0;
        bus_b.req_addr  = '0;
        bus_b.req_wdata = '0;
        bus_b.mem_rdy   = 1'b1;
        checks   = 0;
        failures = 0;
        @(posedge clk);
        #1;

        // Reset holds everything at zero even with both requesting.
        vec("rst_hold0", 2'b11, 2'b00, 2'b00, 16'h0001, 16'h0002, 32'h0, 1'b1, 2'b00, 32'h0);
        vec("rst_hold1", 2'b11, 2'b00, 2'b00, 16'h0001, 16'h0002, 32'h0, 1'b1, 2'b00, 32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Round robin starting at requester 0.
        vec("rr0", 2'b11, 2'b00, 2'b00, 16'h0001, 16'h0002, 32'h0, 1'b1, 2'b01, 32'hC0DE_0001);
        vec("rr1", 2'b11, 2'b00, 2'b00, 16'h0003, 16'h0002, 32'h0, 1'b1, 2'b10, 32'hC0DE_0002);
        vec("rr2", 2'b11, 2'b00, 2'b00, 16'h0003, 16'h0004, 32'h0, 1'b1, 2'b01, 32'hC0DE_0003);
        vec("rr3", 2'b11, 2'b00, 2'b01, 16'h0004, 16'h0004, 32'h0, 1'b1, 2'b10, 32'hC0DE_0004);

        // Locked sequence by requester 0 with a 3-cycle gap; requester 1 waits throughout.
        vec("lk_rd4", 2'b11, 2'b00, 2'b01, 16'h0004, 16'h0007, 32'h0, 1'b1, 2'b01, 32'hC0DE_0004);
        vec("lk_rd5", 2'b11, 2'b00, 2'b01, 16'h0005, 16'h0007, 32'h0, 1'b1, 2'b01, 32'hC0DE_0005);
        vec("gap0", 2'b10, 2'b00, 2'b00, 16'h0000, 16'h0007, 32'h0, 1'b1, 2'b00, 32'h0);
        vec("gap1", 2'b10, 2'b00, 2'b00, 16'h0000, 16'h0007, 32'h0, 1'b1, 2'b00, 32'h0);
        vec("gap2", 2'b10, 2'b00, 2'b00, 16'h0000, 16'h0007, 32'h0, 1'b1, 2'b00, 32'h0);
        vec("lk_wr6", 2'b11, 2'b01, 2'b00, 16'h0006, 16'h0007, 32'hDEAD_BEEF, 1'b1, 2'b01,
            32'h0);
        vec("post_lk", 2'b11, 2'b00, 2'b00, 16'h0006, 16'h0007, 32'h0, 1'b1, 2'b10,
            32'hC0DE_0007);
        vec("rd_wr6", 2'b01, 2'b00, 2'b00, 16'h0006, 16'h0000, 32'h0, 1'b1, 2'b01,
            32'hDEAD_BEEF);

        // Backpressure with a read in flight; ptr must hold across the stall.
        vec("bp_rd8", 2'b11, 2'b00, 2'b00, 16'h0009, 16'h0008, 32'h0, 1'b1, 2'b10,
            32'hC0DE_0008);
        vec("bp_st0", 2'b11, 2'b00, 2'b00, 16'h0009, 16'h000A, 32'h0, 1'b0, 2'b00, 32'h0);
        vec("bp_st1", 2'b11, 2'b00, 2'b00, 16'h0009, 16'h000A, 32'h0, 1'b0, 2'b00, 32'h0);
        vec("bp_rd9", 2'b11, 2'b00, 2'b00, 16'h0009, 16'h000A, 32'h0, 1'b1, 2'b01,
            32'hC0DE_0009);
        vec("bp_rdA", 2'b10, 2'b00, 2'b00, 16'h0000, 16'h000A, 32'h0, 1'b1, 2'b10,
            32'hC0DE_000A);
        for (int i = 0; i < 3; i++) begin
            vec("idle_a", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b1, 2'b00, 32'h0);
        end

        // RD_LAT=3: locked read, then 1-cycle reset; read is dropped and lock released.
        vec_b("b_lk_rd", 2'b01, 2'b01, 16'h0010, 16'h0000, 2'b01, 1'b0);
        rst_b = 1'b0;
        vec_b("b_in_rst", 2'b10, 2'b00, 16'h0000, 16'h0020, 2'b00, 1'b0);
        rst_b = 1'b1;
        vec_b("b_unlock", 2'b10, 2'b00, 16'h0000, 16'h0020, 2'b10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            vec_b("b_idle", 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0);
        end

        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain: got pending a=%0d b=%0d want 0 0", qa.size(), qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
